// File: rtl/axis_rr_arbiter.sv
// Per-packet round-robin arbiter merging NS AXI-Stream sources onto one sink.
// The data path is combinational. The lock, grant and packet count are registered.
module axis_rr_arbiter #(
    parameter int unsigned NS = 4,
    parameter int unsigned DW = 16,
    parameter int unsigned CW = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NS*DW-1:0] s_tdata,
    input  logic [NS-1:0]    s_tvalid,
    input  logic [NS-1:0]    s_tlast,
    output logic [NS-1:0]    s_tready,
    output logic [DW-1:0]    m_tdata,
    output logic             m_tvalid,
    output logic             m_tlast,
    input  logic             m_tready,
    output logic [NS-1:0]    grant,
    output logic             busy,
    output logic [CW-1:0]    pkt_count
);
    localparam int unsigned IW = (NS > 1) ? $clog2(NS) : 1;

    typedef enum logic {IDLE, PASS} state_t;

    state_t        state;
    logic [NS-1:0] grant_r;
    logic [IW-1:0] last_r;
    logic [IW-1:0] owner;
    logic [IW-1:0] pick;
    logic [IW-1:0] cand;
    logic          pick_vld;

    // Index of the current owner, recovered from the one-hot grant
    always_comb begin
        owner = '0;
        for (int i = 0; i < int'(NS); i++) begin
            if (grant_r[i]) owner = IW'(i);
        end
    end

    // First requester searching circularly from last_r+1
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        cand     = '0;
        for (int k = 1; k <= int'(NS); k++) begin
            cand = IW'((int'(last_r) + k) % int'(NS));
            if (!pick_vld && s_tvalid[cand]) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
        end
    end

    // Owner-selected pass-through; everything held at zero outside PASS
    always_comb begin
        m_tdata  = '0;
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        s_tready = '0;
        if (state == PASS) begin
            for (int i = 0; i < int'(NS); i++) begin
                if (grant_r[i]) begin
                    m_tdata     = s_tdata[i*DW +: DW];
                    m_tvalid    = s_tvalid[i];
                    m_tlast     = s_tlast[i];
                    s_tready[i] = m_tready;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant_r   <= '0;
            last_r    <= IW'(NS - 1);
            pkt_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        grant_r <= NS'(1) << pick;
                        state   <= PASS;
                    end
                end
                PASS: begin
                    // The lock is released only when the tlast beat is accepted
                    if (m_tvalid && m_tready && m_tlast) begin
                        last_r    <= owner;
                        grant_r   <= '0;
                        pkt_count <= pkt_count + CW'(1);
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign grant = grant_r;
    assign busy  = (state == PASS);

endmodule
